ahci_regs_arbiter: RTL and testbench

//  Shares the single register-memory access port (addr/we/re/din/dout) between NUM_REQ

---
 rtl/ahci_regs_arbiter.sv | 156 +++++++++++++++
 tb/tb_ahci_regs_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/ahci_regs_arbiter.sv
// Round-robin arbiter that shares the single AHCI register-memory port between
// NUM_REQ requesters (0 = ahci_fsm, 1 = ahci_fis_receive, 2 = ahci_fis_transmit).
// One access is granted per clock. A requester can hold a lock across a
// read-modify-write sequence. Read data is returned with a one-hot rvalid tag
// READ_REG_LATENCY cycles after the memory sees regs_re[0].
//
// Handshake: a requester raises req with its req_we/req_addr/req_wdata/req_lock
// stable and keeps them stable until it sees ack in the same cycle. The transfer
// happens on the clock edge that closes a cycle with ack high. The requester must
// present new inputs (or drop req) right after that edge. Dropping req before
// ack is legal; the request is then simply not served.
module ahci_regs_arbiter #(
    parameter int NUM_REQ          = 3,
    parameter int ADDRESS_BITS     = 10,
    parameter int READ_REG_LATENCY = 2
) (
    input  logic                           mclk,
    input  logic                           hba_rst_n,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ-1:0]             req_lock,
    input  logic [NUM_REQ-1:0]             req_we,
    input  logic [NUM_REQ*ADDRESS_BITS-1:0] req_addr,
    input  logic [NUM_REQ*32-1:0]          req_wdata,
    output logic [NUM_REQ-1:0]             ack,
    output logic [NUM_REQ-1:0]             rvalid,
    output logic [31:0]                    rdata,
    output logic [ADDRESS_BITS-1:0]        regs_addr,
    output logic                           regs_we,
    output logic [1:0]                     regs_re,
    output logic [31:0]                    regs_din,
    input  logic [31:0]                    regs_dout
);

    localparam int IW = $clog2(NUM_REQ);
    localparam logic [IW-1:0] LAST_IDX = IW'(NUM_REQ - 1);

    // Arbitration state: last winner, plus the optional lock owner.
    logic [IW-1:0]      rr_last;
    logic               lock_valid;
    logic [IW-1:0]      lock_owner;

    // Combinational grant for the current cycle.
    logic [NUM_REQ-1:0] owner_mask;
    logic [NUM_REQ-1:0] eligible;
    logic               grant_valid;
    logic [IW-1:0]      grant_idx;
    logic [NUM_REQ-1:0] grant_vec;
    logic               grant_is_read;
    logic [IW-1:0]      cand_idx;
    int                 cand;

    // Read-tag pipeline: one-hot owner of each in-flight read.
    logic [NUM_REQ-1:0] tag_pipe [READ_REG_LATENCY+1];

    // Pick the winner: only the lock owner while locked, otherwise round-robin from rr_last+1.
    always_comb begin
        owner_mask             = '0;
        owner_mask[lock_owner] = 1'b1;
        eligible               = lock_valid ? (req & owner_mask) : req;
        grant_valid            = 1'b0;
        grant_idx              = '0;
        cand                   = 0;
        cand_idx               = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = int'(rr_last) + k;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = IW'(cand);
            if (!grant_valid && eligible[cand_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = cand_idx;
            end
        end
        // Nothing is accepted while reset is being applied.
        if (!hba_rst_n) begin
            grant_valid = 1'b0;
        end
    end

    // Decode the winner into the one-hot ack and note whether it is a read.
    always_comb begin
        grant_vec            = '0;
        grant_vec[grant_idx] = grant_valid;
        grant_is_read        = grant_valid && !req_we[grant_idx];
    end

    assign ack = grant_vec;

    // Round-robin pointer: remember the last winner; idle cycles leave it untouched.
    always_ff @(posedge mclk) begin
        if (!hba_rst_n) begin
            rr_last <= LAST_IDX;
        end else if (grant_valid) begin
            rr_last <= grant_idx;
        end
    end

    // Lock ownership: taken by a locked ack, dropped by an unlocked ack to the owner
    // or when the owner has neither req nor req_lock raised.
    always_ff @(posedge mclk) begin
        if (!hba_rst_n) begin
            lock_valid <= 1'b0;
            lock_owner <= '0;
        end else if (grant_valid) begin
            if (req_lock[grant_idx]) begin
                lock_valid <= 1'b1;
                lock_owner <= grant_idx;
            end else if (lock_valid && (grant_idx == lock_owner)) begin
                lock_valid <= 1'b0;
            end
        end else if (lock_valid && !req[lock_owner] && !req_lock[lock_owner]) begin
            lock_valid <= 1'b0;
        end
    end

    // Issue stage: register the winner's access toward the memory one cycle after ack.
    always_ff @(posedge mclk) begin
        if (!hba_rst_n) begin
            regs_addr <= '0;
            regs_din  <= '0;
            regs_we   <= 1'b0;
            regs_re   <= 2'b00;
        end else begin
            regs_re[1] <= regs_re[0];
            if (grant_valid) begin
                regs_addr  <= req_addr[int'(grant_idx)*ADDRESS_BITS +: ADDRESS_BITS];
                regs_din   <= req_wdata[int'(grant_idx)*32 +: 32];
                regs_we    <= req_we[grant_idx];
                regs_re[0] <= !req_we[grant_idx];
            end else begin
                regs_we    <= 1'b0;
                regs_re[0] <= 1'b0;
            end
        end
    end

    // Tag pipeline: carry each read's owner alongside the memory latency; reset flushes it.
    always_ff @(posedge mclk) begin
        if (!hba_rst_n) begin
            for (int i = 0; i <= READ_REG_LATENCY; i++) begin
                tag_pipe[i] <= '0;
            end
        end else begin
            tag_pipe[0] <= grant_is_read ? grant_vec : '0;
            for (int i = 1; i <= READ_REG_LATENCY; i++) begin
                tag_pipe[i] <= tag_pipe[i-1];
            end
        end
    end

    // Read data is the memory output as-is; the tag says whose it is.
    assign rvalid = tag_pipe[READ_REG_LATENCY];
    assign rdata  = regs_dout;

endmodule

// File: tb/tb_ahci_regs_arbiter.sv
// Directed bench for ahci_regs_arbiter with a small register-memory model
// (two-cycle read latency, preset contents 0xA0000000 | address).
module tb_ahci_regs_arbiter;

    localparam int NR  = 3;
    localparam int AB  = 10;
    localparam int LAT = 2;

    // clock / reset
    logic mclk = 1'b0;
    logic hba_rst_n;
    always #5 mclk = ~mclk;

    logic [NR-1:0]    req;
    logic [NR-1:0]    req_lock;
    logic [NR-1:0]    req_we;
    logic [NR*AB-1:0] req_addr;
    logic [NR*32-1:0] req_wdata;
    logic [NR-1:0]    ack;
    logic [NR-1:0]    rvalid;
    logic [31:0]      rdata;
    logic [AB-1:0]    regs_addr;
    logic             regs_we;
    logic [1:0]       regs_re;
    logic [31:0]      regs_din;
    logic [31:0]      regs_dout;

    int vectors     = 0;
    int miscompares = 0;

    ahci_regs_arbiter #(
        .NUM_REQ          (NR),
        .ADDRESS_BITS     (AB),
        .READ_REG_LATENCY (LAT)
    ) dut (
        .mclk      (mclk),
        .hba_rst_n (hba_rst_n),
        .req       (req),
        .req_lock  (req_lock),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .ack       (ack),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .regs_addr (regs_addr),
        .regs_we   (regs_we),
        .regs_re   (regs_re),
        .regs_din  (regs_din),
        .regs_dout (regs_dout)
    );

    // register memory model: address captured with re, data out with regen
    logic [31:0]   mem [0:1023];
    logic [AB-1:0] rd_addr_q;
    always @(posedge mclk) begin
        if (!hba_rst_n) begin
            for (int i = 0; i < 1024; i++) begin
                mem[i] <= 32'hA000_0000 | 32'(i);
            end
            rd_addr_q <= '0;
            regs_dout <= '0;
        end else begin
            if (regs_we) mem[regs_addr] <= regs_din;
            if (regs_re[0]) rd_addr_q <= regs_addr;
            if (regs_re[1]) regs_dout <= mem[rd_addr_q];
        end
    end

    // driver tasks
    task automatic next_cycle();
        @(negedge mclk);
    endtask

    task automatic set_port(input int i, input logic [AB-1:0] a, input logic [31:0] d);
        req_addr[i*AB +: AB]  = a;
        req_wdata[i*32 +: 32] = d;
    endtask

    // scoreboard compare
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        hba_rst_n = 1'b0;
        req = '0; req_lock = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        repeat (3) @(negedge mclk);
        #1;
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_rvalid", 32'(rvalid), 32'h0);
        chk("rst_we", 32'(regs_we), 32'h0);
        chk("rst_re", 32'(regs_re), 32'h0);
        chk("rst_addr", 32'(regs_addr), 32'h0);
        chk("rst_din", regs_din, 32'h0);

        // single read by requester 0
        next_cycle(); hba_rst_n = 1'b1; set_port(0, 10'h012, 32'h0); req = 3'b001; #1;
        chk("t1_ack", 32'(ack), 32'h1);
        next_cycle(); req = '0; #1;
        chk("t1_ack_drop", 32'(ack), 32'h0);
        chk("t1_re_t1", 32'(regs_re), 32'h1);
        chk("t1_addr", 32'(regs_addr), 32'h012);
        chk("t1_we", 32'(regs_we), 32'h0);
        chk("t1_rvalid_t1", 32'(rvalid), 32'h0);
        next_cycle(); #1;
        chk("t1_re_t2", 32'(regs_re), 32'h2);
        chk("t1_rvalid_t2", 32'(rvalid), 32'h0);
        next_cycle(); #1;
        chk("t1_rvalid_t3", 32'(rvalid), 32'h1);
        chk("t1_rdata", rdata, 32'hA000_0012);
        chk("t1_re_t3", 32'(regs_re), 32'h0);

        // consecutive writes by requesters 1 and 2
        next_cycle();
        set_port(1, 10'h020, 32'hDEAD_BEEF); set_port(2, 10'h021, 32'h5);
        req = 3'b110; req_we = 3'b110; #1;
        chk("t3_ack1", 32'(ack), 32'h2);
        next_cycle(); req = 3'b100; #1;
        chk("t3_ack2", 32'(ack), 32'h4);
        chk("t3_we_a", 32'(regs_we), 32'h1);
        chk("t3_addr_a", 32'(regs_addr), 32'h020);
        chk("t3_din_a", regs_din, 32'hDEAD_BEEF);
        chk("t3_re_a", 32'(regs_re), 32'h0);
        next_cycle(); req = '0; #1;
        chk("t3_ack_idle", 32'(ack), 32'h0);
        chk("t3_we_b", 32'(regs_we), 32'h1);
        chk("t3_addr_b", 32'(regs_addr), 32'h021);
        chk("t3_din_b", regs_din, 32'h5);
        next_cycle(); req_we = '0; #1;
        chk("t3_we_end", 32'(regs_we), 32'h0);

        // all three requesting reads for six cycles: 0,1,2,0,1,2
        set_port(0, 10'h100, 32'h0); set_port(1, 10'h101, 32'h0); set_port(2, 10'h102, 32'h0);
        for (int k = 0; k < 9; k++) begin
            next_cycle(); req = (k < 6) ? 3'b111 : 3'b000; #1;
            if (k < 6) chk("t2_ack", 32'(ack), 32'h1 << (k % 3));
            else       chk("t2_ack_idle", 32'(ack), 32'h0);
            if (k >= 1 && k <= 6) begin
                chk("t2_addr", 32'(regs_addr), 32'h100 + 32'((k - 1) % 3));
                chk("t2_re0", 32'(regs_re[0]), 32'h1);
            end
            if (k >= 3) begin
                chk("t2_rvalid", 32'(rvalid), 32'h1 << ((k - 3) % 3));
                chk("t2_rdata", rdata, 32'hA000_0100 + 32'((k - 3) % 3));
            end
        end

        // interleaved reads by 0 then 2
        next_cycle(); set_port(0, 10'h030, 32'h0); set_port(2, 10'h032, 32'h0); req = 3'b101; #1;
        chk("t5_ack0", 32'(ack), 32'h1);
        next_cycle(); req = 3'b100; #1;
        chk("t5_ack2", 32'(ack), 32'h4);
        next_cycle(); req = '0; #1;
        chk("t5_rvalid_none", 32'(rvalid), 32'h0);
        next_cycle(); #1;
        chk("t5_rvalid0", 32'(rvalid), 32'h1);
        chk("t5_rdata0", rdata, 32'hA000_0030);
        next_cycle(); #1;
        chk("t5_rvalid2", 32'(rvalid), 32'h4);
        chk("t5_rdata2", rdata, 32'hA000_0032);

        // locked read-modify-write by 0 while 1 keeps requesting
        next_cycle(); set_port(0, 10'h014, 32'h0); set_port(1, 10'h040, 32'h0);
        req = 3'b011; req_lock = 3'b001; req_we = 3'b000; #1;
        chk("t4_ack_rd", 32'(ack), 32'h1);
        next_cycle(); req = 3'b010; #1;
        chk("t4_lock_hold1", 32'(ack), 32'h0);
        next_cycle(); #1;
        chk("t4_lock_hold2", 32'(ack), 32'h0);
        next_cycle(); #1;
        chk("t4_lock_hold3", 32'(ack), 32'h0);
        chk("t4_rvalid", 32'(rvalid), 32'h1);
        chk("t4_rdata", rdata, 32'hA000_0014);
        chk("t4_no_write_yet", 32'(regs_we), 32'h0);
        next_cycle(); set_port(0, 10'h014, 32'hA000_0015);
        req = 3'b011; req_lock = 3'b000; req_we = 3'b001; #1;
        chk("t4_ack_wr", 32'(ack), 32'h1);
        next_cycle(); req = 3'b010; req_we = 3'b000; #1;
        chk("t4_ack_1", 32'(ack), 32'h2);
        chk("t4_we", 32'(regs_we), 32'h1);
        chk("t4_addr", 32'(regs_addr), 32'h014);
        chk("t4_din", regs_din, 32'hA000_0015);
        next_cycle(); req = '0; #1;
        chk("t4_re1", 32'(regs_re), 32'h1);
        chk("t4_addr1", 32'(regs_addr), 32'h040);
        next_cycle();
        next_cycle(); #1;
        chk("t4_rvalid1", 32'(rvalid), 32'h2);
        chk("t4_rdata1", rdata, 32'hA000_0040);

        // read back the RMW result through requester 2
        next_cycle(); set_port(2, 10'h014, 32'h0); req = 3'b100; #1;
        chk("rb_ack", 32'(ack), 32'h4);
        next_cycle(); req = '0;
        next_cycle();
        next_cycle(); #1;
        chk("rb_rvalid", 32'(rvalid), 32'h4);
        chk("rb_rdata", rdata, 32'hA000_0015);

        // reset while a read by requester 1 is in flight
        next_cycle(); set_port(1, 10'h050, 32'h0); req = 3'b010; #1;
        chk("t6_ack", 32'(ack), 32'h2);
        next_cycle(); req = '0; #1;
        chk("t6_re", 32'(regs_re), 32'h1);
        next_cycle(); hba_rst_n = 1'b0; req = 3'b111; #1;
        chk("t6_ack_in_rst", 32'(ack), 32'h0);
        next_cycle(); hba_rst_n = 1'b1; #1;
        chk("t6_rvalid", 32'(rvalid), 32'h0);
        chk("t6_re_clr", 32'(regs_re), 32'h0);
        chk("t6_we_clr", 32'(regs_we), 32'h0);
        chk("t6_addr_clr", 32'(regs_addr), 32'h0);
        chk("t6_din_clr", regs_din, 32'h0);
        chk("t6_first_grant", 32'(ack), 32'h1);
        next_cycle(); req = '0; #1;
        chk("t6_rvalid_late", 32'(rvalid), 32'h0);
        repeat (4) next_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
